// File: rtl/count_en_gen_if.sv
// count_en_gen_if
//   Groups the request/enable signals of count_en_gen.
//   key_in    : raw asynchronous request (may bounce)
//   rpt_en    : synchronous auto-repeat enable level
//   count_en  : single-cycle enable pulse toward the counter
//   key_level : debounced request level
//   master drives the request side; slave is the count_en_gen side.
interface count_en_gen_if;
  logic key_in;
  logic rpt_en;
  logic count_en;
  logic key_level;

  modport master (
    output key_in,
    output rpt_en,
    input  count_en,
    input  key_level
  );

  modport slave (
    input  key_in,
    input  rpt_en,
    output count_en,
    output key_level
  );
endinterface

// File: rtl/count_en_gen.sv
// count_en_gen
//   Turns a raw, bouncing request line into clean single-cycle count enable
//   pulses, with optional auto-repeat while the request is held.
//   clk  : system clock, rising edge
//   clr  : asynchronous active-low clear
//   bus  : count_en_gen_if.slave (key_in, rpt_en in; count_en, key_level out)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | request released and debounced, waiting for key_s=1
//   PRESS_DB   | key_s=1 seen, counting stable samples before accepting
//   HELD       | press accepted, waiting for hold time before auto-repeat
//   REPEAT     | auto-repeating, one pulse every REP_CYCLES
//   RELEASE_DB | key_s=0 seen, counting stable samples before releasing
module count_en_gen #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int REP_CYCLES  = 8,
  parameter int TMR_W       = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  count_en_gen_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] DB_LAST   = TMR_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             s1_q, key_s_q;
  logic             count_en_q, count_en_d;
  logic             key_level_q, key_level_d;

  // Two-flop synchronizer; only key_s_q is used by the FSM.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q    <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      s1_q    <= bus.key_in;
      key_s_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      count_en_q  <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_en_q  <= count_en_d;
      key_level_q <= key_level_d;
    end
  end

  // Release (key_s_q=0) is tested first in every pressed state, so a pulse
  // falling due on the edge that detects a release is dropped.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_en_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = PRESS_DB;
          timer_d = '0;
        end
      end
      PRESS_DB: begin
        if (!key_s_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d    = HELD;
          timer_d    = '0;
          count_en_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      HELD: begin
        if (!key_s_q) begin
          state_d = RELEASE_DB;
          timer_d = '0;
        end else if (rpt_en_hit(bus.rpt_en, timer_q)) begin
          state_d    = REPEAT;
          timer_d    = '0;
          count_en_d = 1'b1;
        end else if (timer_q != HOLD_LAST) begin
          // Holds at HOLD_LAST while rpt_en=0 so a later rpt_en=1 repeats at once.
          timer_d = timer_q + TMR_ONE;
        end
      end
      REPEAT: begin
        if (!key_s_q) begin
          state_d = RELEASE_DB;
          timer_d = '0;
        end else if (!bus.rpt_en) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == REP_LAST) begin
          timer_d    = '0;
          count_en_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      RELEASE_DB: begin
        if (key_s_q) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    key_level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_DB);
  end

  function automatic logic rpt_en_hit(input logic en, input logic [TMR_W-1:0] t);
    return en && (t == HOLD_LAST);
  endfunction

  assign bus.count_en  = count_en_q;
  assign bus.key_level = key_level_q;

endmodule

// File: tb/tb_count_en_gen.sv
module tb_count_en_gen;

  logic clk;
  logic clr;

  count_en_gen_if bus ();

  count_en_gen dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         cyc;
  int         exp_q[$];
  logic [3:0] cnt_q;
  logic       prev_ce;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: wait for the falling edge, number the preceding rising edge,
  // and score any pulse against the expected-edge queue.
  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    if (bus.count_en === 1'b1) begin
      cnt_q = cnt_q + 4'd1;
      chk("no_back_to_back", {31'd0, prev_ce}, 32'd0);
      chk("pulse_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse_edge", cyc, e);
      end
    end
    prev_ce = (bus.count_en === 1'b1);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  int c;
  int d;

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    cnt_q   = 4'd0;
    prev_ce = 1'b0;
    clr        = 1'b0;
    bus.key_in = 1'b0;
    bus.rpt_en = 1'b0;

    // Reset held with key_in toggling
    for (int i = 0; i < 10; i++) begin
      bus.key_in = (i % 2 == 0);
      tick();
      chk("rst_count_en", bus.count_en, 0);
      chk("rst_key_level", bus.key_level, 0);
    end
    bus.key_in = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle_count_en", bus.count_en, 0);
      chk("idle_key_level", bus.key_level, 0);
    end

    // Clean press, no repeat: one pulse after E6, release after R6
    cnt_q = 4'd0;
    c = cyc;
    bus.key_in = 1'b1;
    exp_q.push_back(c + 7);
    run_to(c + 6);
    chk("press_level_pre", bus.key_level, 0);
    tick();
    chk("press_level_post", bus.key_level, 1);
    run_to(c + 40);
    c = cyc;
    bus.key_in = 1'b0;
    run_to(c + 6);
    chk("release_level_pre", bus.key_level, 1);
    tick();
    chk("release_level_post", bus.key_level, 0);
    run_to(c + 12);
    chk("press_missed", exp_q.size(), 0);
    chk("press_q", cnt_q, 4'd1);

    // Bounce pattern, then stable 1
    cnt_q = 4'd0;
    c = cyc;
    begin
      logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        bus.key_in = pat[i];
        tick();
      end
    end
    bus.key_in = 1'b1;
    exp_q.push_back(c + 14);
    run_to(c + 13);
    chk("bounce_no_pulse", cnt_q, 4'd0);
    run_to(c + 20);
    chk("bounce_q", cnt_q, 4'd1);
    bus.key_in = 1'b0;
    run_to(c + 34);
    chk("bounce_missed", exp_q.size(), 0);
    chk("bounce_level", bus.key_level, 0);

    // Auto-repeat: key held for edges E0..E59
    cnt_q = 4'd0;
    bus.rpt_en = 1'b1;
    c = cyc;
    bus.key_in = 1'b1;
    foreach (exp_q[i]) exp_q.delete(i);
    begin
      int offs [6] = '{6, 22, 30, 38, 46, 54};
      for (int i = 0; i < 6; i++) exp_q.push_back(c + 1 + offs[i]);
    end
    run_to(c + 60);
    bus.key_in = 1'b0;
    run_to(c + 75);
    chk("rep_missed", exp_q.size(), 0);
    chk("rep_q", cnt_q, 4'd6);
    chk("rep_level", bus.key_level, 0);

    // Release glitch in HELD: one-sample drop restarts the hold timer
    cnt_q = 4'd0;
    c = cyc;
    bus.key_in = 1'b1;
    exp_q.push_back(c + 7);
    exp_q.push_back(c + 30);
    exp_q.push_back(c + 38);
    run_to(c + 10);
    bus.key_in = 1'b0;
    tick();
    bus.key_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("glitch_level", bus.key_level, 1);
    end
    run_to(c + 40);
    bus.key_in = 1'b0;
    run_to(c + 55);
    chk("glitch_missed", exp_q.size(), 0);
    chk("glitch_q", cnt_q, 4'd3);

    // Reset mid-REPEAT, right after a pulse, off the clock edge
    cnt_q = 4'd0;
    c = cyc;
    bus.key_in = 1'b1;
    exp_q.push_back(c + 7);
    exp_q.push_back(c + 23);
    exp_q.push_back(c + 31);
    run_to(c + 31);
    chk("mid_pulse_seen", bus.count_en, 1);
    #2;
    clr = 1'b0;
    #1;
    chk("mid_rst_count_en", bus.count_en, 0);
    chk("mid_rst_key_level", bus.key_level, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_hold_count_en", bus.count_en, 0);
    end
    d = cyc;
    clr = 1'b1;
    exp_q.push_back(d + 7);
    run_to(d + 6);
    chk("mid_level_pre", bus.key_level, 0);
    tick();
    chk("mid_level_post", bus.key_level, 1);
    bus.key_in = 1'b0;
    bus.rpt_en = 1'b0;
    run_to(d + 20);
    chk("mid_missed", exp_q.size(), 0);
    chk("mid_level_end", bus.key_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
